// File: rtl/controller_ram_pkg.sv
// Shared types and helpers for the controller data RAM and its port-B arbiter.
// The RAM itself is fixed at 256 x 32 with byte enables.
package controller_ram_pkg;

  localparam int unsigned RAM_ADDR_W = 8;
  localparam int unsigned RAM_DATA_W = 32;
  localparam int unsigned RAM_BE_W   = RAM_DATA_W / 8;

  typedef struct packed {
    logic                  read;
    logic                  write;
    logic                  lock;
    logic [RAM_ADDR_W-1:0] address;
    logic [RAM_BE_W-1:0]   byteenable;
    logic [RAM_DATA_W-1:0] writedata;
  } ram_req_t;

  // Index of the set bit in a one-hot vector of up to eight entries.
  function automatic int unsigned onehot2bin(input logic [7:0] oh);
    int unsigned b;
    b = 0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) b = b | unsigned'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/controller_data_ram_arbiter_rr_pick.sv
// Rotating priority encoder: lowest set request at or above ptr, wrapping modulo NUM_REQ.
// Purely combinational; returns the winner both one-hot and as an index.
module rr_pick
  import controller_ram_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               vld,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] rot_oh;

  always_comb begin
    // Rotate so that ptr lands on bit 0, take the lowest set bit, rotate back.
    rot    = NUM_REQ'({req, req} >> ptr);
    rot_oh = rot & (~rot + NUM_REQ'(1));
    grant  = NUM_REQ'(({rot_oh, rot_oh} << ptr) >> NUM_REQ);
    vld    = |req;
    idx    = IDX_W'(onehot2bin(8'(grant)));
  end

endmodule

// File: rtl/controller_data_ram_arbiter.sv
// Round-robin arbiter sharing controller data RAM port B among NUM_REQ Avalon-MM requesters,
// with per-owner lock for atomic RMW, a global freeze and a fixed 1-cycle read return.
module controller_data_ram_arbiter
  import controller_ram_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = RAM_ADDR_W,
  parameter int unsigned DATA_W  = RAM_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       freeze,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ-1:0]         req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
  input  logic [NUM_REQ*DATA_W-1:0]  req_writedata,
  output logic [NUM_REQ-1:0]         req_waitrequest,
  output logic [DATA_W-1:0]          req_readdata,
  output logic [NUM_REQ-1:0]         req_readdatavalid,
  output logic [ADDR_W-1:0]          address2,
  output logic [DATA_W/8-1:0]        byteenable2,
  output logic                       chipselect2,
  output logic                       write2,
  output logic [DATA_W-1:0]          writedata2,
  output logic                       clken2,
  input  logic [DATA_W-1:0]          readdata2
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               lock_vld_q, lock_vld_d;
  logic [IDX_W-1:0]   lock_owner_q, lock_owner_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] eligible;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               run;
  logic               gnt_vld;
  ram_req_t           sel;

  always_comb begin
    active = req_read | req_write;
    // A held lock hides everyone but the owner, even when the owner is idle.
    if (lock_vld_q) eligible = active & (NUM_REQ'(1) << lock_owner_q);
    else            eligible = active;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req   (eligible),
    .ptr   (ptr_q),
    .vld   (pick_vld),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    run     = reset_n & ~freeze;
    gnt_vld = run & pick_vld;

    sel.read       = req_read[pick_idx];
    sel.write      = req_write[pick_idx];
    sel.lock       = req_lock[pick_idx];
    sel.address    = req_address[pick_idx*ADDR_W +: ADDR_W];
    sel.byteenable = req_byteenable[pick_idx*BE_W +: BE_W];
    sel.writedata  = req_writedata[pick_idx*DATA_W +: DATA_W];
  end

  always_comb begin
    req_waitrequest   = ~(pick_grant & {NUM_REQ{gnt_vld}});
    chipselect2       = gnt_vld;
    write2            = gnt_vld & sel.write;
    clken2            = run;
    address2          = gnt_vld ? sel.address : addr_q;
    byteenable2       = sel.byteenable;
    writedata2        = sel.writedata;
    // Reset kills a return that was scheduled by the last accepted read.
    req_readdatavalid = rvalid_q & {NUM_REQ{reset_n}};
    req_readdata      = (|rvalid_q) ? readdata2 : rdata_q;
  end

  always_comb begin
    ptr_d        = ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    rvalid_d     = '0;
    addr_d       = addr_q;
    rdata_d      = (|rvalid_q) ? readdata2 : rdata_q;

    if (gnt_vld) begin
      addr_d     = sel.address;
      lock_vld_d = sel.lock;
      if (sel.lock) begin
        lock_owner_d = pick_idx;
      end else if (pick_idx == IDX_W'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = pick_idx + IDX_W'(1);
      end
      // Read together with write is a write; no data comes back.
      if (sel.read && !sel.write) rvalid_d = pick_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q        <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      rvalid_q     <= '0;
    end else begin
      ptr_q        <= ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      rvalid_q     <= rvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    rdata_q <= rdata_d;
  end

endmodule

// File: tb/tb_controller_data_ram_arbiter.sv
// Bench for controller_data_ram_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of grant order, lock ownership and RAM contents.
module tb_controller_data_ram_arbiter;

  localparam int N  = 3;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, freeze;
  logic [N-1:0]    req_read, req_write, req_lock;
  logic [N*AW-1:0] req_address;
  logic [N*BW-1:0] req_byteenable;
  logic [N*DW-1:0] req_writedata;
  logic [N-1:0]    req_waitrequest, req_readdatavalid;
  logic [DW-1:0]   req_readdata;
  logic [AW-1:0]   address2;
  logic [BW-1:0]   byteenable2;
  logic            chipselect2, write2, clken2;
  logic [DW-1:0]   writedata2, readdata2;

  controller_data_ram_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .freeze            (freeze),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_lock          (req_lock),
    .req_address       (req_address),
    .req_byteenable    (req_byteenable),
    .req_writedata     (req_writedata),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .address2          (address2),
    .byteenable2       (byteenable2),
    .chipselect2       (chipselect2),
    .write2            (write2),
    .writedata2        (writedata2),
    .clken2            (clken2),
    .readdata2         (readdata2)
  );

  // RAM port B: registered output, clock-enabled.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (clken2 && chipselect2) begin
      if (write2) begin
        for (int b = 0; b < BW; b++)
          if (byteenable2[b]) ram[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
      end else begin
        readdata2 <= ram[address2];
      end
    end
  end

  // Stimulus for the current cycle.
  logic [N-1:0]  s_rd, s_wr, s_lk;
  logic [AW-1:0] s_addr [N];
  logic [BW-1:0] s_be [N];
  logic [DW-1:0] s_wd [N];
  logic          s_frz, s_rstn;

  // Reference model state.
  int            m_ptr, m_owner, m_pend, g_cur;
  bit            m_lock, m_last_vld;
  logic [AW-1:0] m_last;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] exp_mem [256];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic drive_check();
    int           g;
    logic [N-1:0] ew, erv;
    reset_n   = s_rstn;
    freeze    = s_frz;
    req_read  = s_rd;
    req_write = s_wr;
    req_lock  = s_lk;
    for (int i = 0; i < N; i++) begin
      req_address[i*AW +: AW]    = s_addr[i];
      req_byteenable[i*BW +: BW] = s_be[i];
      req_writedata[i*DW +: DW]  = s_wd[i];
    end
    #4;
    g = -1;
    if (s_rstn && !s_frz) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && (s_rd[i] || s_wr[i]) && (!m_lock || i == m_owner)) g = i;
      end
    end
    ew  = '1;
    erv = '0;
    if (g >= 0) ew[g] = 1'b0;
    if (s_rstn && m_pend >= 0) erv[m_pend] = 1'b1;
    check("waitrequest", req_waitrequest, ew);
    check("chipselect2", chipselect2, g >= 0);
    check("write2", write2, (g >= 0) ? s_wr[g] : 1'b0);
    check("clken2", clken2, s_rstn && !s_frz);
    if (g >= 0) begin
      check("address2", address2, s_addr[g]);
      check("byteenable2", byteenable2, s_be[g]);
      check("writedata2", writedata2, s_wd[g]);
    end else if (m_last_vld) begin
      check("address2_hold", address2, m_last);
    end
    check("readdatavalid", req_readdatavalid, erv);
    if (erv != '0) check("readdata", req_readdata, m_pend_data);
    g_cur = g;
  endtask

  task automatic step();
    @(posedge clk);
    if (!s_rstn) begin
      m_ptr   = 0;
      m_lock  = 0;
      m_owner = 0;
      m_pend  = -1;
    end else begin
      m_pend = -1;
      if (g_cur >= 0) begin
        m_last     = s_addr[g_cur];
        m_last_vld = 1;
        if (s_wr[g_cur]) begin
          for (int b = 0; b < BW; b++)
            if (s_be[g_cur][b]) exp_mem[s_addr[g_cur]][b*8 +: 8] = s_wd[g_cur][b*8 +: 8];
        end else begin
          m_pend      = g_cur;
          m_pend_data = exp_mem[s_addr[g_cur]];
        end
        m_lock = s_lk[g_cur];
        if (s_lk[g_cur]) m_owner = g_cur;
        else             m_ptr = (g_cur + 1) % N;
      end
    end
    #1;
  endtask

  task automatic cyc();
    drive_check();
    step();
  endtask

  task automatic idle();
    s_rd   = '0;
    s_wr   = '0;
    s_lk   = '0;
    s_frz  = 1'b0;
    s_rstn = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    s_rstn = 1'b0;
    cyc();
    s_rstn = 1'b1;
  endtask

  initial begin
    logic [N-1:0] gv;
    for (int a = 0; a < 256; a++) begin
      ram[a]     = '0;
      exp_mem[a] = '0;
    end
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0;
      s_be[i]   = '1;
      s_wd[i]   = '0;
    end
    m_ptr = 0; m_owner = 0; m_pend = -1; m_lock = 0; m_last_vld = 0; m_last = '0;
    m_pend_data = '0;
    idle();
    s_rstn = 1'b0;
    #1;
    cyc();
    cyc();

    // Single read of a known word.
    idle(); s_wr[0] = 1; s_addr[0] = 8'h10; s_be[0] = 4'hF; s_wd[0] = 32'hDEADBEEF;
    cyc();
    idle(); s_rd[0] = 1; s_addr[0] = 8'h10;
    drive_check();
    check("t1_wait0", req_waitrequest[0], 1'b0);
    check("t1_addr", address2, 8'h10);
    step();
    idle();
    drive_check();
    check("t1_rvalid", req_readdatavalid, 3'b001);
    check("t1_rdata", req_readdata, 32'hDEADBEEF);
    step();

    // Continuous reads from all three: strict rotation.
    do_reset();
    idle(); s_rd = 3'b111;
    for (int i = 0; i < N; i++) s_addr[i] = AW'(8'h10 + i);
    for (int k = 0; k < 6; k++) begin
      drive_check();
      gv = ~req_waitrequest;
      check("t2_grant", gv, 3'b001 << (k % 3));
      if (k > 0) check("t2_rvalid", req_readdatavalid, 3'b001 << ((k - 1) % 3));
      step();
    end

    // Locked read-modify-write by requester 1.
    do_reset();
    idle(); s_rd[1] = 1; s_lk[1] = 1; s_addr[1] = 8'h20;
    drive_check();
    check("t3_lock_rd", req_waitrequest, 3'b101);
    step();
    idle(); s_rd[0] = 1; s_rd[2] = 1; s_addr[0] = 8'h01; s_addr[2] = 8'h02;
    for (int k = 0; k < 2; k++) begin
      drive_check();
      check("t3_blocked", req_waitrequest, 3'b111);
      step();
    end
    s_wr[1] = 1; s_lk[1] = 0; s_be[1] = 4'h3; s_wd[1] = 32'h0000ABCD;
    drive_check();
    check("t3_wr_gnt", req_waitrequest, 3'b101);
    step();
    s_wr[1] = 0;
    drive_check();
    check("t3_next_req2", req_waitrequest, 3'b011);
    step();
    idle(); s_rd[0] = 1; s_addr[0] = 8'h20;
    cyc();
    idle();
    drive_check();
    check("t3_merged", req_readdata, 32'h0000ABCD);
    step();

    // Freeze holds a pending write off for four cycles.
    idle(); s_wr[0] = 1; s_addr[0] = 8'h30; s_be[0] = 4'hF; s_wd[0] = 32'h12345678; s_frz = 1;
    for (int k = 0; k < 4; k++) begin
      drive_check();
      check("t4_clken", clken2, 1'b0);
      check("t4_wait0", req_waitrequest[0], 1'b1);
      step();
    end
    s_frz = 0;
    drive_check();
    check("t4_accept", req_waitrequest[0], 1'b0);
    step();

    // Reset right after an accepted read swallows its return.
    do_reset();
    idle(); s_rd[2] = 1; s_addr[2] = 8'h10;
    drive_check();
    check("t5_gnt2", req_waitrequest[2], 1'b0);
    step();
    idle(); s_rstn = 0;
    drive_check();
    check("t5_no_rvalid", req_readdatavalid, 3'b000);
    step();
    s_rstn = 1; s_rd = 3'b111;
    drive_check();
    check("t5_gnt0", req_waitrequest, 3'b110);
    step();

    // Read and write together behave as a write.
    idle(); s_rd[1] = 1; s_wr[1] = 1; s_addr[1] = 8'h40; s_be[1] = 4'hF; s_wd[1] = 32'hCAFEF00D;
    drive_check();
    check("t6_write2", write2, 1'b1);
    step();
    idle();
    drive_check();
    check("t6_no_rvalid", req_readdatavalid[1], 1'b0);
    step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      s_rstn = ($urandom_range(0, 60) != 0);
      s_frz  = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) begin
        int op;
        op        = $urandom_range(0, 4);
        s_rd[i]   = (op == 1 || op == 2);
        s_wr[i]   = (op == 3);
        s_lk[i]   = ($urandom_range(0, 4) == 0);
        s_addr[i] = AW'($urandom_range(0, 15));
        s_be[i]   = BW'($urandom);
        s_wd[i]   = $urandom;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
